// File: rtl/dw_square_rr_sched.sv
// dw_square_rr_sched: shares one squarer between NUM_REQ requesters.
// Round-robin arbiter picks one request per cycle. A two-stage stallable pipeline
// follows it: stage 1 holds the operand magnitude, stage 2 holds the square.
// Results leave in acceptance order and are tagged with the requester index.
module dw_square_rr_sched #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ-1:0]         req_tc,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [2*WIDTH-1:0]         res_square,
    output logic [ID_W-1:0]            res_id
);

    logic [ID_W-1:0]      ptr_reg;
    logic [ID_W-1:0]      ptr_next;
    logic                 s1_valid_reg;
    logic [WIDTH-1:0]     s1_mag_reg;
    logic [ID_W-1:0]      s1_id_reg;
    logic                 s2_valid_reg;
    logic [2*WIDTH-1:0]   s2_square_reg;
    logic [ID_W-1:0]      s2_id_reg;

    logic                 adv;
    logic                 grant_valid;
    logic [ID_W-1:0]      grant_id;
    logic [WIDTH-1:0]     grant_mag;
    logic [WIDTH-1:0]     mag_all [NUM_REQ];
    logic [2*WIDTH-1:0]   s1_ext;

    // The whole pipeline moves only when the output slot is empty or is being drained.
    assign adv = !s2_valid_reg || res_ready;

    // Compute the magnitude for every requester. Only the granted one is used.
    // The most negative two's-complement value wraps to 2^(WIDTH-1). That is the
    // correct unsigned magnitude.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mag
            logic [WIDTH-1:0] a_i;
            assign a_i = req_a[gi*WIDTH +: WIDTH];
            assign mag_all[gi] = (req_tc[gi] && a_i[WIDTH-1]) ? (~a_i + WIDTH'(1)) : a_i;
        end
    endgenerate

    // Round-robin scan starting at ptr. The first valid requester wins.
    // Nothing is granted while stalled or while reset is held.
    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_id    = '0;
        grant_mag   = '0;
        req_ready   = '0;
        ptr_next    = ptr_reg;
        if (rst_n && adv) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(ptr_reg) + k) % NUM_REQ;
                if (!grant_valid && req_valid[idx]) begin
                    grant_valid    = 1'b1;
                    grant_id       = ID_W'(idx);
                    grant_mag      = mag_all[idx];
                    req_ready[idx] = 1'b1;
                    ptr_next       = ID_W'((idx + 1) % NUM_REQ);
                end
            end
        end
    end

    // Pointer moves just past the requester that was served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else if (grant_valid) begin
            ptr_reg <= ptr_next;
        end
    end

    // Stage 1 captures magnitude and id of the accepted request. A bubble is
    // recorded when nothing was accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_mag_reg   <= '0;
            s1_id_reg    <= '0;
        end else if (adv) begin
            s1_valid_reg <= grant_valid;
            if (grant_valid) begin
                s1_mag_reg <= grant_mag;
                s1_id_reg  <= grant_id;
            end
        end
    end

    assign s1_ext = {{WIDTH{1'b0}}, s1_mag_reg};

    // Stage 2 squares the magnitude at full width. It holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg  <= 1'b0;
            s2_square_reg <= '0;
            s2_id_reg     <= '0;
        end else if (adv) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_square_reg <= s1_ext * s1_ext;
                s2_id_reg     <= s1_id_reg;
            end
        end
    end

    assign res_valid  = s2_valid_reg;
    assign res_square = s2_square_reg;
    assign res_id     = s2_id_reg;

endmodule

// File: tb/tb_dw_square_rr_sched.sv
// Testbench for dw_square_rr_sched. A behavioural model tracks round-robin
// priority and in-flight results. A compare process checks the DUT against the
// model on every falling edge. Directed phases pin hand-computed values, and a
// randomized phase exercises backpressure.
module tb_dw_square_rr_sched;

    localparam int W   = 8;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic               clk;
    logic               rst_n;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N*W-1:0]     req_a;
    logic [N-1:0]       req_tc;
    logic               res_valid;
    logic               res_ready;
    logic [2*W-1:0]     res_square;
    logic [IDW-1:0]     res_id;

    int total = 0;
    int bad   = 0;

    dw_square_rr_sched #(.WIDTH(W), .NUM_REQ(N), .ID_W(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_tc     (req_tc),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_square (res_square),
        .res_id     (res_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Square of the operand read as a signed or unsigned integer.
    function automatic int sqv(input logic [W-1:0] a, input logic tc);
        int v;
        v = int'(a);
        if (tc && v >= (1 << (W-1))) v = v - (1 << W);
        return v * v;
    endfunction

    // Behavioural model: priority pointer plus two occupancy slots.
    int m_ptr = 0;
    bit m1v = 0, m2v = 0;
    int m1id = 0, m2id = 0, m1sq = 0, m2sq = 0;
    int cg;
    int ci;
    bit cadv;
    logic [N-1:0] cexp;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_req_ready", req_ready, 0);
            chk("reset_res_valid", res_valid, 0);
            chk("reset_res_square", res_square, 0);
            chk("reset_res_id", res_id, 0);
            m_ptr = 0; m1v = 0; m2v = 0;
        end else begin
            cadv = !m2v || res_ready;
            cg = -1;
            if (cadv) begin
                for (int k = 0; k < N; k++) begin
                    ci = (m_ptr + k) % N;
                    if (cg < 0 && req_valid[ci]) cg = ci;
                end
            end
            cexp = '0;
            if (cg >= 0) cexp[cg] = 1'b1;
            chk("req_ready", req_ready, cexp);
            chk("res_valid", res_valid, m2v);
            if (m2v) begin
                chk("res_square", res_square, m2sq);
                chk("res_id", res_id, m2id);
            end
            if (cadv) begin
                m2v = m1v; m2sq = m1sq; m2id = m1id;
                m1v = (cg >= 0);
                if (cg >= 0) begin
                    m1id  = cg;
                    m1sq  = sqv(req_a[cg*W +: W], req_tc[cg]);
                    m_ptr = (cg + 1) % N;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("async_reset_res_valid", res_valid, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    logic [N-1:0] e_ready;

    initial begin
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_tc = '0; res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Single negative operand from requester 0.
        step(); req_valid = 4'b0001; req_a[7:0] = 8'hFB; req_tc = 4'b0001;
        @(negedge clk); chk("t1_grant0", req_ready, 4'b0001);
        step(); req_valid = '0;
        @(negedge clk); chk("t1_latency_gap", res_valid, 0);
        step();
        @(negedge clk);
        chk("t1_res_valid", res_valid, 1);
        chk("t1_square", res_square, 16'd25);
        chk("t1_id", res_id, 0);

        // Boundary operands from requester 2.
        step(); req_valid = 4'b0100; req_a[23:16] = 8'h80; req_tc = 4'b0100;
        step(); req_tc = 4'b0000;
        step(); req_a[23:16] = 8'hFF;
        @(negedge clk); chk("t2_80_tc", res_square, 16'h4000);
        step(); req_valid = '0;
        @(negedge clk); chk("t2_80_unsigned", res_square, 16'h4000);
        step();
        @(negedge clk); chk("t2_ff_unsigned", res_square, 16'hFE01); chk("t2_id", res_id, 2);

        // All requesters valid continuously.
        pulse_reset();
        for (int k = 0; k < 8; k++) begin
            step(); req_valid = 4'hF; req_a = $urandom; req_tc = 4'($urandom);
            @(negedge clk);
            e_ready = 4'(1 << (k % 4));
            chk("t3_rr_grant", req_ready, e_ready);
            if (k >= 2) chk("t3_rr_id", res_id, 64'((k - 2) % 4));
        end
        step(); req_valid = '0;
        repeat (2) step();

        // Requesters 1 and 3 with a five-cycle output stall.
        for (int k = 0; k < 12; k++) begin
            step();
            req_valid = (k < 10) ? 4'b1010 : 4'b0000;
            req_a = $urandom; req_tc = 4'($urandom);
            res_ready = !(k >= 2 && k < 7);
            @(negedge clk);
            if (k >= 2 && k < 7) chk("t4_stall_ready", req_ready, 0);
        end
        res_ready = 1'b1;
        repeat (3) step();

        // Wraparound: ptr reaches 2, then only requester 1 is valid.
        step(); req_valid = 4'b0010;
        @(negedge clk); chk("t5_set_ptr", req_ready, 4'b0010);
        step(); req_valid = 4'b0010;
        @(negedge clk); chk("t5_wrap", req_ready, 4'b0010);
        step(); req_valid = 4'b0110;
        @(negedge clk); chk("t5_prio2", req_ready, 4'b0100);
        step(); req_valid = '0;
        repeat (2) step();

        // Asynchronous reset with two operations in flight.
        step(); req_valid = 4'b1001; req_a = $urandom;
        step();
        step(); req_valid = '0;
        #1 chk("t6_inflight", res_valid, 1);
        #1 rst_n = 1'b0;
        #1 chk("t6_async_drop", res_valid, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step(); req_valid = 4'b0110;
        @(negedge clk); chk("t6_first_grant", req_ready, 4'b0010);

        // Randomized traffic with random backpressure.
        for (int k = 0; k < 1500; k++) begin
            step();
            req_valid = 4'($urandom);
            req_a     = $urandom;
            req_tc    = 4'($urandom);
            res_ready = ($urandom_range(0, 9) < 7);
        end
        step(); req_valid = '0; res_ready = 1'b1;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dw_square_rr_sched.md
Name: dw_square_rr_sched

Overview:
- Shares one signed/unsigned squarer between NUM_REQ requesters.
- Round-robin arbitration with a valid/ready handshake on each request port.
- Two-stage stallable pipeline (magnitude, then product) feeding one result port tagged with the requester index.
- Sits between per-channel power/energy estimators and the single squarer instance.

Parameters:
- WIDTH, 8, operand width in bits; result is 2*WIDTH.
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, 2, requester-index width; must equal ceil(log2(NUM_REQ)).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_a  input  NUM_REQ*WIDTH  operands; requester i occupies bits [i*WIDTH +: WIDTH].
- req_tc  input  NUM_REQ  per-requester two's-complement flag.
- res_valid  output  1  result valid.
- res_ready  input  1  downstream accept.
- res_square  output  2*WIDTH  squared value.
- res_id  output  ID_W  index of the requester that issued the result.

Behaviour:
- Reset (async, rst_n=0):
  - req_ready=0, res_valid=0, res_square=0, res_id=0.
  - Both stage-valid flags cleared; round-robin pointer ptr=0.
  - Effective immediately, including mid-operation; all in-flight operations are discarded.
- Pipeline advance:
  - adv = !s2_valid || res_ready.
  - When adv=0, all stages hold and req_ready=0.
- Arbitration (combinational):
  - When adv=1, grant the first i with req_valid[i]=1, scanning ptr, ptr+1, … mod NUM_REQ.
  - req_ready[grant]=1; all other bits 0.
  - If no request is valid, req_ready=0 and ptr is unchanged.
  - req_ready depends on req_valid; requesters must not make req_valid depend on req_ready.
- Transfer: occurs when req_valid[i] && req_ready[i]. On transfer, ptr <= (i+1) mod NUM_REQ.
- Stage 1 (registered on transfer):
  - mag = (tc && a[WIDTH-1]) ? (~a + 1) : a, WIDTH bits.
  - The most negative value maps to 2^(WIDTH-1), unsigned.
  - Stores mag and id; s1_valid <= transfer.
- Stage 2 (registered when adv):
  - s2 product = mag*mag, full 2*WIDTH bits, no truncation.
  - s2_valid <= s1_valid; id is carried along.
- Output:
  - res_valid = s2_valid; res_square and res_id come from stage-2 registers.
  - Values stay stable while res_valid && !res_ready.
- Latency and throughput:
  - Transfer in cycle N gives res_valid in cycle N+2 with no backpressure.
  - One result per cycle sustained.
- Simultaneous events:
  - A result popped and a new request accepted in the same cycle is legal.
  - Full throughput holds with res_ready tied high.
- Ordering: results leave in acceptance order. No reordering and no drops under any backpressure pattern.
- Bubbles: an empty stage 1 propagates as s2_valid=0 and does not block.
- Unused high ID_W codes never appear on res_id.

Test Plan:
- Reset, then requester 0 sends a=8'hFB, tc=1 -> req_ready[0]=1 the same cycle; two cycles later res_valid=1, res_square=16'd25, res_id=0.
- Requester 2 sends a=8'h80: tc=1 -> 16'h4000; tc=0 -> 16'h4000 (128²); a=8'hFF, tc=0 -> 16'hFE01.
- All four requesters hold valid continuously, res_ready=1 -> grants 0,1,2,3,0,1,… one per cycle; res_id follows the same sequence with 2-cycle lag.
- Requesters 1 and 3 valid, res_ready low for 5 cycles after the first result -> after pipeline fill, req_ready=0 and res_square/res_id stay stable; on release, results resume in order with no loss or duplication.
- ptr=2 with only requester 1 valid -> requester 1 granted (wrap), then ptr=2; requester 2 then has top priority.
- rst_n pulsed low asynchronously mid-stream with two operations in flight -> res_valid drops at once and no stale result appears after release; the first grant after reset goes to the lowest-index valid requester.
